gerador_instrucoes: RTL
=======================

# gerador_instrucoes

Sequential RV32I instruction encoder. It accepts decoded instruction fields (type, registers, funct, immediate) over a valid/ready handshake and packs them into 32-bit words using the same opcode set the control decoder recognises: R, I-immediate, I-load, S, B. It then writes each word into instruction memory at consecutive word addresses. It is used by the test/loader path to build programs in instruction memory that the core then fetches and decodes.

## Interface
- LARGURA_END, default 8: instruction-memory word-address width.
- ENDERECO_INICIAL, default 0: first write address. Must be less than 2^LARGURA_END.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- entrada_valida  in  1  instruction fields valid.
- entrada_pronta  out  1  block can accept fields this cycle.
- tipo  in  3  instruction type:
  - 0 = R, 1 = I-imm, 2 = I-load, 3 = S, 4 = B.
  - 5–7 are invalid.
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field; used by R only.
- imediato  in  32  signed immediate (byte offset for B).
- mem_escreve  out  1  write request to instruction memory.
- mem_endereco  out  LARGURA_END  write word address.
- mem_dado  out  32  encoded instruction.
- mem_pronta  in  1  memory accepts the write this cycle.
- limpar  in  1  synchronous clear.
- contador  out  LARGURA_END+1  number of words written.
- cheia  out  1  last address has been written.
- erro  out  1  sticky error flag.

## Operation
- **FSM states:** OCIOSO, ESCREVE, CHEIA.
- **Ready:** entrada_pronta = (estado == OCIOSO) & ~limpar. It is combinational.
- **Accept:** an accept is entrada_valida & entrada_pronta at a rising edge. On a legal accept:
  - the encoded word is registered into mem_dado;
  - the FSM goes to OCIOSO → ESCREVE.
- **Opcodes:** R 0110011, I-imm 0010011, I-load 0000011, S 0100011, B 1100011.
- **Encoding:**
  - R: funct7 | rs2 | rs1 | funct3 | rd | op.
  - I: imm[11:0] | rs1 | funct3 | rd | op.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | op.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | op.
  - rs2 is ignored for I; rd is ignored for S and B.
- **Legality checks:**
  - I and S immediates must lie in −2048..2047.
  - B immediates must lie in −4096..4094 and be even.
  - tipo 5–7 is illegal.
- **Illegal accept:**
  - The handshake completes.
  - erro is set to 1; it is sticky.
  - Nothing is written; address, contador and mem_dado are unchanged.
  - The FSM stays in OCIOSO.
- **ESCREVE:**
  - mem_escreve = 1; mem_endereco and mem_dado are held stable.
  - On mem_escreve & mem_pronta, contador increments.
  - If mem_endereco = 2^LARGURA_END−1: go to CHEIA; the address does not wrap.
  - Otherwise: the address increments and the FSM returns to OCIOSO.
- **CHEIA:**
  - cheia = 1, entrada_pronta = 0, mem_escreve = 0.
  - Only limpar or reset exits this state.
  - Holding valid while full does not set erro.
- **limpar, from any state:**
  - the FSM goes to OCIOSO;
  - the address returns to ENDERECO_INICIAL;
  - contador and erro go to 0;
  - any pending write is dropped.
  - limpar has priority over accept and over write completion in the same cycle.
- **Reset values:**
  - estado = OCIOSO.
  - mem_escreve = 0, mem_dado = 0.
  - mem_endereco = ENDERECO_INICIAL.
  - contador = 0, cheia = 0, erro = 0.
  - entrada_pronta = 1 when limpar = 0.
- **Reset mid-write:** the write is abandoned immediately; there is no partial state.

## Timing
- Accept at edge N: mem_escreve = 1 and the word is valid on mem_dado from after edge N.
- The write completes at the first edge where mem_pronta = 1.
- The next accept is possible one cycle after completion.
- Peak throughput is 1 word per 2 cycles.
- With mem_pronta held low, mem_escreve, mem_endereco and mem_dado stay constant for any number of cycles.
- erro rises after the edge that accepts the illegal entry.
- cheia rises after the edge completing the write to the last address. contador then equals 2^LARGURA_END − ENDERECO_INICIAL.
- Every output is registered, except entrada_pronta, which is combinational.

## Test plan
- **Encoding, mem_pronta = 1 always, starting at address 0:**
  - Stimulus: R add x3,x1,x2; I-imm addi x1,x0,−1; I-load lw x5,8(x2); S sw x5,12(x2); B beq x1,x2,−8.
  - Required: words 0x002081B3, 0xFFF00093, 0x00812283, 0x00512623, 0xFE208CE3 at addresses 0–4.
  - Required: contador = 5, erro = 0.
- **Backpressure:**
  - Stimulus: accept add x3,x1,x2; hold mem_pronta = 0 for 3 cycles.
  - Required: mem_escreve = 1, address 0 and data 0x002081B3 stable for those 3 cycles; entrada_pronta = 0.
  - Required: the write completes on the 4th cycle and contador = 1.
- **Illegal B immediate:**
  - Stimulus: B with imediato = 3; then I with imediato = 2048; then tipo = 6.
  - Required: each handshake completes; erro = 1 after the first one.
  - Required: mem_escreve never asserts and contador = 0.
  - Required: a following legal addi is written at address 0.
- **Full, LARGURA_END = 2, ENDERECO_INICIAL = 0:**
  - Stimulus: 4 legal writes.
  - Required: cheia = 1, contador = 4, entrada_pronta = 0.
  - Stimulus: a 5th entrada_valida.
  - Required: no write and erro = 0.
- **limpar:**
  - Stimulus: limpar during ESCREVE, asserted together with mem_pronta.
  - Required: no count increment; next cycle mem_escreve = 0, address = 0, contador = 0, erro = 0.
  - Stimulus: limpar asserted in CHEIA.
  - Required: the block returns to OCIOSO with cheia = 0.
- **Async reset mid-write:**
  - Stimulus: drop rst_n between edges while mem_escreve = 1.
  - Required: mem_escreve and contador go to 0 immediately, without waiting for a clock edge.
  - Required: after release, the first legal accept writes to ENDERECO_INICIAL.

Source files
------------

// File: rtl/gerador_instrucoes_if.sv
// Field/handshake and instruction-memory write bus of the RV32I encoder.
// The master side is the loader: it supplies the decoded fields and the
// memory ready. The slave side is the encoder.
interface gerador_instrucoes_if #(
   parameter int LARGURA_END = 8
) ();

   // Decoded instruction fields and handshake
   logic                   entrada_valida;
   logic                   entrada_pronta;
   logic [2:0]             tipo;
   logic [4:0]             rd;
   logic [4:0]             rs1;
   logic [4:0]             rs2;
   logic [2:0]             funct3;
   logic [6:0]             funct7;
   logic [31:0]            imediato;

   // Instruction-memory write port
   logic                   mem_escreve;
   logic [LARGURA_END-1:0] mem_endereco;
   logic [31:0]            mem_dado;
   logic                   mem_pronta;

   modport master (
      output entrada_valida, tipo, rd, rs1, rs2, funct3, funct7, imediato,
      output mem_pronta,
      input  entrada_pronta, mem_escreve, mem_endereco, mem_dado
   );

   modport slave (
      input  entrada_valida, tipo, rd, rs1, rs2, funct3, funct7, imediato,
      input  mem_pronta,
      output entrada_pronta, mem_escreve, mem_endereco, mem_dado
   );

endinterface

// File: rtl/gerador_instrucoes.sv
// Sequential RV32I instruction encoder. Accepts decoded fields (R, I-imm,
// I-load, S, B), packs them into a 32-bit word and writes it to instruction
// memory at consecutive word addresses, starting at ENDERECO_INICIAL.
// Illegal entries are swallowed and raise a sticky error. Once the last
// address is written the block stays full until limpar or reset.
// ENDERECO_INICIAL must be below 2**LARGURA_END.
module gerador_instrucoes #(
   parameter int LARGURA_END      = 8,
   parameter int ENDERECO_INICIAL = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gerador_instrucoes_if.slave  bus,
   input  logic                 limpar,
   output logic [LARGURA_END:0] contador,
   output logic                 cheia,
   output logic                 erro
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      ESCREVE = 2'd1,
      CHEIA   = 2'd2
   } estado_t;

   localparam int LARGURA_CONT = LARGURA_END + 1;

   localparam logic [LARGURA_END-1:0] END_INICIAL = LARGURA_END'(ENDERECO_INICIAL);
   localparam logic [LARGURA_END-1:0] END_ULTIMO  = '1;

   // tipo codes
   localparam logic [2:0] TIPO_R      = 3'd0;
   localparam logic [2:0] TIPO_I_IMM  = 3'd1;
   localparam logic [2:0] TIPO_I_LOAD = 3'd2;
   localparam logic [2:0] TIPO_S      = 3'd3;
   localparam logic [2:0] TIPO_B      = 3'd4;

   // Opcodes shared with the control decoder
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_IMM  = 7'b0010011;
   localparam logic [6:0] OP_I_LOAD = 7'b0000011;
   localparam logic [6:0] OP_S      = 7'b0100011;
   localparam logic [6:0] OP_B      = 7'b1100011;

   // State and datapath registers
   estado_t                estado_q,   estado_d;
   logic [LARGURA_END-1:0] endereco_q, endereco_d;
   logic [31:0]            dado_q,     dado_d;
   logic [LARGURA_END:0]   contador_q, contador_d;
   logic                   erro_q,     erro_d;
   logic                   escreve_q;
   logic                   cheia_q;

   // Encoder results
   logic [31:0]            palavra;
   logic                   legal;
   logic signed [31:0]     imm_s;
   logic                   imm_12_ok;
   logic                   imm_b_ok;
   logic                   aceite;
   logic                   escrita_feita;

   assign imm_s = bus.imediato;

   // I and S take a 12-bit signed immediate; B takes a 13-bit even byte offset
   assign imm_12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
   assign imm_b_ok  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !bus.imediato[0];

   // Pack the fields into an RV32I word and flag whether the entry is legal
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; an unassigned path would infer a latch.
      palavra = '0;
      legal   = 1'b0;
      unique case (bus.tipo)
         TIPO_R: begin
            palavra = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_R};
            legal   = 1'b1;
         end
         TIPO_I_IMM: begin
            palavra = {bus.imediato[11:0], bus.rs1, bus.funct3, bus.rd, OP_I_IMM};
            legal   = imm_12_ok;
         end
         TIPO_I_LOAD: begin
            palavra = {bus.imediato[11:0], bus.rs1, bus.funct3, bus.rd, OP_I_LOAD};
            legal   = imm_12_ok;
         end
         TIPO_S: begin
            palavra = {bus.imediato[11:5], bus.rs2, bus.rs1, bus.funct3,
                       bus.imediato[4:0], OP_S};
            legal   = imm_12_ok;
         end
         TIPO_B: begin
            palavra = {bus.imediato[12], bus.imediato[10:5], bus.rs2, bus.rs1,
                       bus.funct3, bus.imediato[4:1], bus.imediato[11], OP_B};
            legal   = imm_b_ok;
         end
         default: begin
            palavra = '0;
            legal   = 1'b0;
         end
      endcase
   end

   // Ready is the only combinational output: idle and not being cleared
   assign bus.entrada_pronta = (estado_q == OCIOSO) && !limpar;
   assign aceite             = bus.entrada_valida && bus.entrada_pronta;
   assign escrita_feita      = (estado_q == ESCREVE) && bus.mem_pronta;

   // Next-state logic; limpar overrides accept and write completion
   always_comb begin
      estado_d   = estado_q;
      endereco_d = endereco_q;
      dado_d     = dado_q;
      contador_d = contador_q;
      erro_d     = erro_q;

      if (limpar) begin
         estado_d   = OCIOSO;
         endereco_d = END_INICIAL;
         contador_d = '0;
         erro_d     = 1'b0;
      end else begin
         unique case (estado_q)
            OCIOSO: begin
               if (aceite) begin
                  if (legal) begin
                     dado_d   = palavra;
                     estado_d = ESCREVE;
                  end else begin
                     erro_d   = 1'b1;
                  end
               end
            end
            ESCREVE: begin
               if (escrita_feita) begin
                  contador_d = contador_q + LARGURA_CONT'(1);
                  if (endereco_q == END_ULTIMO) begin
                     estado_d = CHEIA;
                  end else begin
                     endereco_d = endereco_q + LARGURA_END'(1);
                     estado_d   = OCIOSO;
                  end
               end
            end
            CHEIA: begin
               estado_d = CHEIA;
            end
            default: begin
               estado_d = OCIOSO;
            end
         endcase
      end
   end

   // State and datapath registers; write strobe and full flag come from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q   <= OCIOSO;
         endereco_q <= END_INICIAL;
         dado_q     <= '0;
         contador_q <= '0;
         erro_q     <= 1'b0;
         escreve_q  <= 1'b0;
         cheia_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         estado_q   <= estado_d;
         endereco_q <= endereco_d;
         dado_q     <= dado_d;
         contador_q <= contador_d;
         erro_q     <= erro_d;
         escreve_q  <= (estado_d == ESCREVE);
         cheia_q    <= (estado_d == CHEIA);
      end
   end

   assign bus.mem_escreve  = escreve_q;
   assign bus.mem_endereco = endereco_q;
   assign bus.mem_dado     = dado_q;
   assign contador         = contador_q;
   assign cheia            = cheia_q;
   assign erro             = erro_q;

endmodule
